// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder
//   Parses the UART receiver's byte stream into actuator commands.
//   Two-byte commands: letter ('a' pump, 'g' faucet, 'l' light) followed by
//   '0' (off) or '1' (on). 'x' alone switches everything off. CR/LF are ignored.
//   A missing argument byte times out, and the pump is forced off after a
//   maximum continuous run time.
//
// Parameters
//   TIMEOUT_CYCLES   cycles allowed between command letter and argument byte
//   PUMP_MAX_CYCLES  maximum continuous pump-on cycles before forced off
//
// Ports
//   clk       system clock
//   rst       asynchronous active-high reset
//   rx_data   received byte, valid while rx_valid=1
//   rx_valid  one-cycle byte strobe
//   bomba_on  pump enable (level)
//   grifo_on  faucet enable (level)
//   luz_on    light enable (level)
//   cmd_ok    one-cycle pulse: command accepted
//   cmd_err   one-cycle pulse: bad letter, bad argument or argument timeout
//   pump_cut  one-cycle pulse: pump forced off by the safety timer
//   last_cmd  letter of the last accepted command
module uart_cmd_decoder #(
    parameter int unsigned TIMEOUT_CYCLES  = 5_000_000,
    parameter int unsigned PUMP_MAX_CYCLES = 1_500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       bomba_on,
    output logic       grifo_on,
    output logic       luz_on,
    output logic       cmd_ok,
    output logic       cmd_err,
    output logic       pump_cut,
    output logic [7:0] last_cmd
);

    localparam int unsigned ARG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [ARG_W-1:0] ARG_LAST  = ARG_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]      PUMP_LAST = 32'(PUMP_MAX_CYCLES - 1);

    localparam logic [7:0] CH_PUMP    = 8'h61;  // 'a'
    localparam logic [7:0] CH_FAUCET  = 8'h67;  // 'g'
    localparam logic [7:0] CH_LIGHT   = 8'h6C;  // 'l'
    localparam logic [7:0] CH_ALL_OFF = 8'h78;  // 'x'
    localparam logic [7:0] CH_ZERO    = 8'h30;  // '0'
    localparam logic [7:0] CH_ONE     = 8'h31;  // '1'
    localparam logic [7:0] CH_LF      = 8'h0A;
    localparam logic [7:0] CH_CR      = 8'h0D;

    typedef enum logic {
        IDLE,
        WAIT_ARG
    } state_t;

    state_t           state_q,    state_d;
    logic [7:0]       letter_q,   letter_d;
    logic [ARG_W-1:0] arg_tmr_q,  arg_tmr_d;
    logic [31:0]      pump_tmr_q, pump_tmr_d;
    logic             bomba_on_q, bomba_on_d;
    logic             grifo_on_q, grifo_on_d;
    logic             luz_on_q,   luz_on_d;
    logic             cmd_ok_q,   cmd_ok_d;
    logic             cmd_err_q,  cmd_err_d;
    logic             pump_cut_q, pump_cut_d;
    logic [7:0]       last_cmd_q, last_cmd_d;

    always_comb begin
        state_d    = state_q;
        letter_d   = letter_q;
        arg_tmr_d  = arg_tmr_q;
        pump_tmr_d = '0;
        bomba_on_d = bomba_on_q;
        grifo_on_d = grifo_on_q;
        luz_on_d   = luz_on_q;
        last_cmd_d = last_cmd_q;
        cmd_ok_d   = 1'b0;
        cmd_err_d  = 1'b0;
        pump_cut_d = 1'b0;

        // Safety timer is evaluated first so that an accepted pump or all-off
        // command on the cutoff cycle overrides it below (no pump_cut then).
        if (bomba_on_q) begin
            if (pump_tmr_q == PUMP_LAST) begin
                bomba_on_d = 1'b0;
                pump_cut_d = 1'b1;
            end else begin
                pump_tmr_d = pump_tmr_q + 32'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CH_PUMP, CH_FAUCET, CH_LIGHT: begin
                            letter_d  = rx_data;
                            arg_tmr_d = '0;
                            state_d   = WAIT_ARG;
                        end
                        CH_ALL_OFF: begin
                            bomba_on_d = 1'b0;
                            grifo_on_d = 1'b0;
                            luz_on_d   = 1'b0;
                            pump_cut_d = 1'b0;
                            pump_tmr_d = '0;
                            cmd_ok_d   = 1'b1;
                            last_cmd_d = CH_ALL_OFF;
                        end
                        CH_LF, CH_CR: begin
                        end
                        default: cmd_err_d = 1'b1;
                    endcase
                end
            end
            WAIT_ARG: begin
                // A byte arriving on the expiry cycle takes priority over the timeout.
                if (rx_valid) begin
                    state_d = IDLE;
                    if (rx_data == CH_ZERO || rx_data == CH_ONE) begin
                        cmd_ok_d   = 1'b1;
                        last_cmd_d = letter_q;
                        case (letter_q)
                            CH_PUMP: begin
                                bomba_on_d = rx_data[0];
                                pump_cut_d = 1'b0;
                                pump_tmr_d = '0;
                            end
                            CH_FAUCET: grifo_on_d = rx_data[0];
                            default:   luz_on_d   = rx_data[0];
                        endcase
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end else if (arg_tmr_q == ARG_LAST) begin
                    cmd_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    arg_tmr_d = arg_tmr_q + ARG_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            letter_q   <= '0;
            arg_tmr_q  <= '0;
            pump_tmr_q <= '0;
            bomba_on_q <= 1'b0;
            grifo_on_q <= 1'b0;
            luz_on_q   <= 1'b0;
            cmd_ok_q   <= 1'b0;
            cmd_err_q  <= 1'b0;
            pump_cut_q <= 1'b0;
            last_cmd_q <= '0;
        end else begin
            state_q    <= state_d;
            letter_q   <= letter_d;
            arg_tmr_q  <= arg_tmr_d;
            pump_tmr_q <= pump_tmr_d;
            bomba_on_q <= bomba_on_d;
            grifo_on_q <= grifo_on_d;
            luz_on_q   <= luz_on_d;
            cmd_ok_q   <= cmd_ok_d;
            cmd_err_q  <= cmd_err_d;
            pump_cut_q <= pump_cut_d;
            last_cmd_q <= last_cmd_d;
        end
    end

    assign bomba_on = bomba_on_q;
    assign grifo_on = grifo_on_q;
    assign luz_on   = luz_on_q;
    assign cmd_ok   = cmd_ok_q;
    assign cmd_err  = cmd_err_q;
    assign pump_cut = pump_cut_q;
    assign last_cmd = last_cmd_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Testbench for uart_cmd_decoder: a small-parameter instance exercised by
// directed scenarios plus random traffic against a behavioural model, and a
// default-parameter instance for the real-baud byte spacing case.
module tb_uart_cmd_decoder;

    localparam int TO = 100;
    localparam int PM = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       bomba_on, grifo_on, luz_on, cmd_ok, cmd_err, pump_cut;
    logic [7:0] last_cmd;

    logic [7:0] rx_data_s = 8'h00;
    logic       rx_valid_s = 1'b0;
    logic       s_bomba, s_grifo, s_luz, s_ok, s_err, s_cut;
    logic [7:0] s_last;

    int n_checks = 0;
    int n_errors = 0;

    uart_cmd_decoder #(.TIMEOUT_CYCLES(TO), .PUMP_MAX_CYCLES(PM)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .bomba_on(bomba_on), .grifo_on(grifo_on), .luz_on(luz_on),
        .cmd_ok(cmd_ok), .cmd_err(cmd_err), .pump_cut(pump_cut), .last_cmd(last_cmd)
    );

    uart_cmd_decoder u_slow (
        .clk(clk), .rst(rst), .rx_data(rx_data_s), .rx_valid(rx_valid_s),
        .bomba_on(s_bomba), .grifo_on(s_grifo), .luz_on(s_luz),
        .cmd_ok(s_ok), .cmd_err(s_err), .pump_cut(s_cut), .last_cmd(s_last)
    );

    always #10 clk = ~clk;

    // Behavioural model: pending letter (0 = none), cycles waited for the
    // argument, and cycles the pump has been running.
    logic [7:0] m_pend = 8'h00, m_last = 8'h00;
    int         m_wait = 0, m_age = 0;
    logic       m_b = 1'b0, m_g = 1'b0, m_l = 1'b0;
    logic       m_ok = 1'b0, m_err = 1'b0, m_cut = 1'b0;

    always @(posedge clk or posedge rst) begin : model
        logic [7:0] pend, last;
        int         wt, age;
        logic       b, g, l, ok, err, cut;
        if (rst) begin
            m_pend <= 8'h00; m_last <= 8'h00; m_wait <= 0; m_age <= 0;
            m_b <= 1'b0; m_g <= 1'b0; m_l <= 1'b0;
            m_ok <= 1'b0; m_err <= 1'b0; m_cut <= 1'b0;
        end else begin
            pend = m_pend; last = m_last; wt = m_wait; age = m_age;
            b = m_b; g = m_g; l = m_l; ok = 1'b0; err = 1'b0; cut = 1'b0;
            if (b) begin
                age++;
                if (age == PM) begin b = 1'b0; cut = 1'b1; age = 0; end
            end
            if (pend == 8'h00) begin
                if (rx_valid) begin
                    case (rx_data)
                        "a", "g", "l": begin pend = rx_data; wt = 0; end
                        "x": begin b = 1'b0; g = 1'b0; l = 1'b0; cut = 1'b0; age = 0; ok = 1'b1; last = "x"; end
                        8'h0A, 8'h0D: begin end
                        default: err = 1'b1;
                    endcase
                end
            end else if (rx_valid) begin
                if (rx_data == "0" || rx_data == "1") begin
                    ok = 1'b1; last = pend;
                    if (pend == "a") begin b = rx_data[0]; cut = 1'b0; age = 0; end
                    else if (pend == "g") g = rx_data[0];
                    else l = rx_data[0];
                end else begin
                    err = 1'b1;
                end
                pend = 8'h00;
            end else begin
                wt++;
                if (wt == TO) begin err = 1'b1; pend = 8'h00; end
            end
            m_pend <= pend; m_last <= last; m_wait <= wt; m_age <= age;
            m_b <= b; m_g <= g; m_l <= l; m_ok <= ok; m_err <= err; m_cut <= cut;
        end
    end

    logic [13:0] dut_v, mv;
    assign dut_v = {bomba_on, grifo_on, luz_on, cmd_ok, cmd_err, pump_cut, last_cmd};
    assign mv    = {m_b, m_g, m_l, m_ok, m_err, m_cut, m_last};

    // Stimulus helpers (drive only). send() returns at the falling edge right
    // after the edge that sampled the byte, so its effects are visible.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (dut_v !== 14'h0) begin n_errors++; $display("FAIL reset_fast: got %h expected 0000", dut_v); end
        n_checks++;
        if ({s_bomba, s_grifo, s_luz, s_ok, s_err, s_cut, s_last} !== 14'h0) begin
            n_errors++; $display("FAIL reset_slow: got %h expected 0000", {s_bomba, s_grifo, s_luz, s_ok, s_err, s_cut, s_last});
        end
        idle(2);
        rst = 1'b0;
        idle(2);
        n_checks++;
        if (dut_v !== 14'h0) begin n_errors++; $display("FAIL reset_after: got %h expected 0000", dut_v); end
    endtask

    task automatic test_baud;
        int oks = 0, errs = 0;
        @(negedge clk);
        rx_valid_s = 1'b1; rx_data_s = 8'h61;
        for (int i = 0; i < 4339; i++) begin
            @(negedge clk);
            rx_valid_s = 1'b0; rx_data_s = 8'($urandom);
            oks += int'(s_ok); errs += int'(s_err);
        end
        rx_valid_s = 1'b1; rx_data_s = 8'h30;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rx_valid_s = 1'b0;
            oks += int'(s_ok); errs += int'(s_err);
        end
        n_checks++;
        if (oks != 1) begin n_errors++; $display("FAIL baud_ok_count: got %0d expected 1", oks); end
        n_checks++;
        if (errs != 0) begin n_errors++; $display("FAIL baud_err_count: got %0d expected 0", errs); end
        n_checks++;
        if ({s_bomba, s_last} !== 9'h061) begin n_errors++; $display("FAIL baud_state: got %h expected 061", {s_bomba, s_last}); end
    endtask

    task automatic test_sequence;
        int oks = 0;
        send("a"); send("1");
        oks += int'(cmd_ok);
        n_checks++;
        if ({bomba_on, grifo_on, luz_on} !== 3'b100) begin n_errors++; $display("FAIL seq_a1: got %b expected 100", {bomba_on, grifo_on, luz_on}); end
        send("l"); send("1");
        oks += int'(cmd_ok);
        n_checks++;
        if ({bomba_on, grifo_on, luz_on} !== 3'b101) begin n_errors++; $display("FAIL seq_l1: got %b expected 101", {bomba_on, grifo_on, luz_on}); end
        send("x");
        oks += int'(cmd_ok);
        n_checks++;
        if ({bomba_on, grifo_on, luz_on, last_cmd} !== {3'b000, 8'h78}) begin
            n_errors++; $display("FAIL seq_x: got %h expected 078", {bomba_on, grifo_on, luz_on, last_cmd});
        end
        n_checks++;
        if (oks != 3) begin n_errors++; $display("FAIL seq_ok_count: got %0d expected 3", oks); end
        n_checks++;
        if (dut_v !== mv) begin n_errors++; $display("FAIL seq_model: got %h expected %h", dut_v, mv); end
    endtask

    task automatic test_timeout;
        send("g");
        for (int k = 1; k <= TO + 3; k++) begin
            @(negedge clk);
            n_checks++;
            if ({cmd_err, cmd_ok} !== {(k == TO), 1'b0}) begin
                n_errors++; $display("FAIL timeout_k%0d: got err/ok %b expected %b", k, {cmd_err, cmd_ok}, {(k == TO), 1'b0});
            end
        end
        send("g"); send("1");
        n_checks++;
        if ({grifo_on, cmd_ok, cmd_err} !== 3'b110) begin n_errors++; $display("FAIL timeout_g1: got %b expected 110", {grifo_on, cmd_ok, cmd_err}); end
    endtask

    task automatic test_bad_input;
        send("q");
        n_checks++;
        if ({cmd_ok, cmd_err} !== 2'b01) begin n_errors++; $display("FAIL bad_q: got %b expected 01", {cmd_ok, cmd_err}); end
        send("l"); send("1");
        send("l"); send("7");
        n_checks++;
        if ({cmd_ok, cmd_err, luz_on} !== 3'b011) begin n_errors++; $display("FAIL bad_l7: got %b expected 011", {cmd_ok, cmd_err, luz_on}); end
        send(8'h0D);
        n_checks++;
        if ({cmd_ok, cmd_err} !== 2'b00) begin n_errors++; $display("FAIL bad_cr: got %b expected 00", {cmd_ok, cmd_err}); end
        send("l"); send("a");
        n_checks++;
        if ({cmd_ok, cmd_err} !== 2'b01) begin n_errors++; $display("FAIL bad_letter_arg: got %b expected 01", {cmd_ok, cmd_err}); end
        n_checks++;
        if (dut_v !== mv) begin n_errors++; $display("FAIL bad_model: got %h expected %h", dut_v, mv); end
    endtask

    task automatic test_pump_cut;
        send("a"); send("1");
        for (int k = 1; k <= PM + 5; k++) begin
            @(negedge clk);
            n_checks++;
            if ({bomba_on, pump_cut} !== {(k < PM), (k == PM)}) begin
                n_errors++; $display("FAIL pump_k%0d: got %b expected %b", k, {bomba_on, pump_cut}, {(k < PM), (k == PM)});
            end
        end
        send("a"); send("1");
        idle(148);
        send("a"); send("1");
        for (int k = 151; k <= PM + 160; k++) begin
            @(negedge clk);
            n_checks++;
            if ({bomba_on, pump_cut} !== {(k < 150 + PM), (k == 150 + PM)}) begin
                n_errors++; $display("FAIL pump_restart_k%0d: got %b expected %b", k, {bomba_on, pump_cut}, {(k < 150 + PM), (k == 150 + PM)});
            end
        end
    endtask

    task automatic test_cut_tie;
        send("a"); send("1");
        idle(PM - 2);
        send("a"); send("1");
        n_checks++;
        if ({bomba_on, pump_cut, cmd_ok} !== 3'b101) begin n_errors++; $display("FAIL tie_a1: got %b expected 101", {bomba_on, pump_cut, cmd_ok}); end
        idle(PM - 2);
        send("a"); send("0");
        n_checks++;
        if ({bomba_on, pump_cut, cmd_ok} !== 3'b001) begin n_errors++; $display("FAIL tie_a0: got %b expected 001", {bomba_on, pump_cut, cmd_ok}); end
        n_checks++;
        if (dut_v !== mv) begin n_errors++; $display("FAIL tie_model: got %h expected %h", dut_v, mv); end
    endtask

    task automatic test_rst_mid;
        send("l"); send("1");
        n_checks++;
        if (luz_on !== 1'b1) begin n_errors++; $display("FAIL rstmid_l1: got %b expected 1", luz_on); end
        send("l");
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (dut_v !== 14'h0) begin n_errors++; $display("FAIL rstmid_async: got %h expected 0000", dut_v); end
        @(negedge clk);
        rst = 1'b0;
        send("1");
        n_checks++;
        if ({cmd_ok, cmd_err, luz_on} !== 3'b010) begin n_errors++; $display("FAIL rstmid_arg: got %b expected 010", {cmd_ok, cmd_err, luz_on}); end
    endtask

    task automatic test_random;
        int quiet = 0;
        int r;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== mv) begin n_errors++; $display("FAIL rand_vec_%0d: got %h expected %h", i, dut_v, mv); end
            n_checks++;
            if (cmd_ok === 1'b1 && cmd_err === 1'b1) begin n_errors++; $display("FAIL rand_okerr_%0d: got ok=1 err=1 expected not both", i); end
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            if (quiet > 0) begin
                quiet--;
            end else begin
                r = $urandom_range(0, 99);
                if (r < 2) begin
                    quiet = $urandom_range(90, 260);
                end else if (r < 40) begin
                    rx_valid = 1'b1;
                    case ($urandom_range(0, 9))
                        0: rx_data = "a";
                        1: rx_data = "g";
                        2: rx_data = "l";
                        3: rx_data = "x";
                        4: rx_data = "0";
                        5, 6: rx_data = "1";
                        7: rx_data = 8'h0D;
                        8: rx_data = 8'h0A;
                        default: rx_data = 8'($urandom);
                    endcase
                end
            end
        end
        rx_valid = 1'b0;
        idle(2);
    endtask

    initial begin
        test_reset;
        test_baud;
        test_sequence;
        test_timeout;
        test_bad_input;
        test_pump_cut;
        test_cut_tie;
        test_rst_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
